spi_target: RTL and testbench

- SPI responder (slave) that forms the far end of the SPI master link used by the MMIO SPI controller.
- Lets an external SPI master exchange bytes with the core through buffered RX/TX byte queues.
- Serial side runs in SPI mode 0, MSB first. sck, cs_n and mosi are oversampled in the system clock domain.
- Core side presents a register-style handshake matching the existing MMIO peripherals.

---
 rtl/spi_target_pkg.sv | 14 +
 rtl/spi_target_sync_fifo.sv | 49 ++++
 rtl/spi_target.sv | 174 +++++++++++++++++
 tb/tb_spi_target.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target: FSM states, synchroniser depth
// and bit-counter width.
package spi_target_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  localparam int SYNC_STAGES = 2;
  localparam int BIT_CNT_W   = 3;

endpackage

// File: rtl/spi_target_sync_fifo.sv
// First-word-fall-through synchronous FIFO; writes when full and reads when
// empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with RX/TX byte FIFOs and sticky error flags.
// Optional per-frame byte counter enabled by defining SPI_TARGET_FRAME_CNT_EN.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int         RX_DEPTH  = 16,
  parameter int         TX_DEPTH  = 16,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic        rx_rd,
  output logic [7:0]  rx_dout,
  output logic        rx_data_avail,
  input  logic        tx_wr,
  input  logic [7:0]  tx_din,
  output logic        tx_full,
  output logic        tx_empty,
  input  logic        err_clr,
  output logic        rx_ovf,
  output logic        tx_unf,
  output logic        frame_err,
  output logic        busy,
  output logic [15:0] frame_bytes
);

  logic [SYNC_STAGES-1:0]  sck_pipe, cs_pipe, mosi_pipe;
  logic                    sck_d, cs_d;
  logic                    sck_sync, cs_sync, mosi_sync;
  logic                    sck_rise, sck_fall, cs_fall, cs_rise;
  state_t                  state, state_next;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic [7:0]              shreg_tx, shreg_rx, tx_head, load_byte;
  logic                    byte_seen, rx_push, rx_full, rx_empty;
  logic                    load_now, tx_pop, shift_rise, shift_fall;
  logic [$clog2(RX_DEPTH):0] rx_count_unused;
  logic [$clog2(TX_DEPTH):0] tx_count_unused;

  // cs_n synchroniser resets to the deasserted level so reset never fakes a frame start.
  always_ff @(posedge clk) begin
    if (Rst) begin
      sck_pipe  <= '0;
      cs_pipe   <= '1;
      mosi_pipe <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], sck};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], cs_n};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_sync;
      cs_d      <= cs_sync;
    end
  end

  assign sck_sync  = sck_pipe[SYNC_STAGES-1];
  assign cs_sync   = cs_pipe[SYNC_STAGES-1];
  assign mosi_sync = mosi_pipe[SYNC_STAGES-1];
  assign sck_rise  = sck_sync & ~sck_d;
  assign sck_fall  = ~sck_sync & sck_d;
  assign cs_fall   = ~cs_sync & cs_d;
  assign cs_rise   = cs_sync & ~cs_d;
  assign busy      = ~cs_sync;

  always_ff @(posedge clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   state_next = SHIFT;
      default: state_next = IDLE;
    endcase
    if (cs_rise) state_next = IDLE;
  end

  // A reload on the falling edge after a completed byte keeps streaming gap-free.
  assign load_now   = ~cs_rise & ((state == LOAD) |
                      ((state == SHIFT) & sck_fall & (bit_cnt == '0) & byte_seen));
  assign load_byte  = tx_empty ? IDLE_BYTE : tx_head;
  assign tx_pop     = load_now & ~tx_empty;
  assign shift_rise = ~cs_rise & (state == SHIFT) & sck_rise;
  assign shift_fall = ~cs_rise & (state == SHIFT) & sck_fall & (bit_cnt != '0);

  // shreg_tx refills with ones so miso (its MSB) idles high outside a frame.
  always_ff @(posedge clk) begin
    if (Rst) begin
      shreg_tx  <= '1;
      shreg_rx  <= '0;
      bit_cnt   <= '0;
      byte_seen <= 1'b0;
      rx_push   <= 1'b0;
    end else begin
      rx_push <= shift_rise & (bit_cnt == '1);
      if (cs_rise) begin
        shreg_tx  <= '1;
        bit_cnt   <= '0;
        byte_seen <= 1'b0;
      end else if (load_now) begin
        shreg_tx <= load_byte;
        bit_cnt  <= '0;
      end else if (shift_rise) begin
        shreg_rx <= {shreg_rx[6:0], mosi_sync};
        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
        if (bit_cnt == '1) byte_seen <= 1'b1;
      end else if (shift_fall) begin
        shreg_tx <= {shreg_tx[6:0], 1'b1};
      end
    end
  end

  assign miso = shreg_tx[7];

  always_ff @(posedge clk) begin
    if (Rst) begin
      rx_ovf    <= 1'b0;
      tx_unf    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_ovf    <= (rx_push & rx_full) | (rx_ovf & ~err_clr);
      tx_unf    <= (load_now & tx_empty) | (tx_unf & ~err_clr);
      frame_err <= (cs_rise & (bit_cnt != '0)) | (frame_err & ~err_clr);
    end
  end

`ifdef SPI_TARGET_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (Rst)                                  frame_cnt <= '0;
    else if (cs_fall)                         frame_cnt <= '0;
    else if (rx_push && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
  end

  assign frame_bytes = frame_cnt;
`else
  assign frame_bytes = 16'h0;
`endif

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (Rst),
    .wr    (rx_push),
    .din   (shreg_rx),
    .rd    (rx_rd),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count_unused)
  );

  assign rx_data_avail = ~rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (Rst),
    .wr    (tx_wr),
    .din   (tx_din),
    .rd    (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count_unused)
  );

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: a queue-based model of the FIFOs and flags,
// a bit-banged mode-0 master, directed scenarios plus randomized traffic.
module tb_spi_target;

  localparam int         RXD  = 16;
  localparam int         TXD  = 16;
  localparam logic [7:0] IDLE = 8'hFF;

  logic        clk = 1'b0;
  logic        Rst, sck, cs_n, mosi, miso;
  logic        rx_rd, rx_data_avail, tx_wr, tx_full, tx_empty, err_clr;
  logic [7:0]  rx_dout, tx_din;
  logic        rx_ovf, tx_unf, frame_err, busy;
  logic [15:0] frame_bytes;

  always #5 clk = ~clk;

  spi_target #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .IDLE_BYTE(IDLE)) dut (
    .clk(clk), .Rst(Rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .rx_rd(rx_rd), .rx_dout(rx_dout), .rx_data_avail(rx_data_avail),
    .tx_wr(tx_wr), .tx_din(tx_din), .tx_full(tx_full), .tx_empty(tx_empty),
    .err_clr(err_clr), .rx_ovf(rx_ovf), .tx_unf(tx_unf), .frame_err(frame_err),
    .busy(busy), .frame_bytes(frame_bytes)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  m_rx[$];
  logic [7:0]  m_tx[$];
  logic        m_ovf, m_unf, m_ferr;
  logic [15:0] m_fb;
  logic        check_en = 1'b0;
  logic [7:0]  frame_q[$];
  logic [7:0]  miso_q[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rx.delete();
    m_tx.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_ferr = 1'b0;
    m_fb = '0;
  endtask

  // Idle-time comparison of every core-visible output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("rx_data_avail", rx_data_avail, m_rx.size() != 0);
      if (m_rx.size() != 0) check_output("rx_dout", rx_dout, m_rx[0]);
      check_output("tx_full", tx_full, m_tx.size() == TXD);
      check_output("tx_empty", tx_empty, m_tx.size() == 0);
      check_output("rx_ovf", rx_ovf, m_ovf);
      check_output("tx_unf", tx_unf, m_unf);
      check_output("frame_err", frame_err, m_ferr);
      check_output("busy_idle", busy, 0);
      check_output("miso_idle", miso, 1);
`ifdef SPI_TARGET_FRAME_CNT_EN
      check_output("frame_bytes", frame_bytes, m_fb);
`else
      check_output("frame_bytes", frame_bytes, 0);
`endif
    end
  end

  task automatic apply_tx_write(input logic [7:0] b);
    @(posedge clk); #1 tx_wr = 1'b1; tx_din = b;
    @(posedge clk); #1 tx_wr = 1'b0;
    if (m_tx.size() < TXD) m_tx.push_back(b);
  endtask

  task automatic apply_rx_read();
    @(posedge clk); #1 rx_rd = 1'b1;
    @(posedge clk); #1 rx_rd = 1'b0;
    if (m_rx.size() != 0) m_rx.delete(0);
  endtask

  task automatic apply_err_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_load(output logic [7:0] b);
    if (m_tx.size() != 0) begin
      b = m_tx[0];
      m_tx.delete(0);
    end else begin
      b = IDLE;
      m_unf = 1'b1;
    end
  endtask

  // Sends frame_q as full bytes at sck = clk/10, then 'partial' extra rises.
  // Without a partial byte the master releases cs_n together with the final sck
  // fall, so the target does not reload for a byte that will never be clocked.
  task automatic apply_frame(input int partial, input bit rd_on_last);
    logic [7:0]  exp_miso, got;
    logic [31:0] r;
    int n;
    n = frame_q.size();
    miso_q.delete();
    @(posedge clk); #1 check_en = 1'b0;
    @(negedge clk); cs_n = 1'b0; sck = 1'b0;
    m_fb = '0;
    repeat (10) @(negedge clk);
    check_output("busy_in_frame", busy, 1);
    for (int b = 0; b < n; b++) begin
      model_load(exp_miso);
      got = '0;
      for (int i = 7; i >= 0; i--) begin
        mosi = frame_q[b][i];
        repeat (5) @(negedge clk);
        sck = 1'b1;
        got[i] = miso;
        if (rd_on_last && b == n-1 && i == 0) begin
          fork
            repeat (5) @(negedge clk);
            begin
              repeat (3) @(posedge clk);
              #1 rx_rd = 1'b1;
              @(posedge clk);
              #1 rx_rd = 1'b0;
            end
            begin
              for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check_output("avail_rd_push", rx_data_avail, 1);
              end
            end
          join
        end else begin
          repeat (5) @(negedge clk);
        end
        sck = 1'b0;
        if (b == n-1 && i == 0 && partial == 0) cs_n = 1'b1;
      end
      check_output("miso_byte", got, exp_miso);
      miso_q.push_back(got);
      if (rd_on_last && b == n-1 && m_rx.size() != 0) m_rx.delete(0);
      if (m_rx.size() == RXD) m_ovf = 1'b1;
      else                    m_rx.push_back(frame_q[b]);
      if (m_fb != 16'hFFFF) m_fb = m_fb + 16'd1;
    end
    if (partial > 0) begin
      model_load(exp_miso);
      for (int i = 0; i < partial; i++) begin
        r = $urandom;
        mosi = r[0];
        repeat (5) @(negedge clk);
        sck = 1'b1;
        repeat (5) @(negedge clk);
        if (i != partial-1) sck = 1'b0;
      end
      cs_n = 1'b1;
      m_ferr = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1 check_en = 1'b1;
    frame_q.delete();
  endtask

  task automatic apply_reset_mid_frame();
    @(posedge clk); #1 check_en = 1'b0;
    @(negedge clk); cs_n = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
    @(posedge clk); #1 Rst = 1'b1;
    @(posedge clk); #1 model_reset();
    check_en = 1'b1;
    check_output("rst_tx_empty", tx_empty, 1);
    check_output("rst_miso", miso, 1);
    check_output("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 check_en = 1'b0; cs_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 Rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_en = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    int nw, nb, nr, part;
    Rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    rx_rd = 1'b0; tx_wr = 1'b0; tx_din = '0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 Rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_tx_empty", tx_empty, 1);
    check_output("reset_miso", miso, 1);
    check_output("reset_avail", rx_data_avail, 0);
    check_output("reset_frame_bytes", frame_bytes, 0);

    // Two-byte exchange with preloaded TX.
    apply_tx_write(8'hA5);
    apply_tx_write(8'h3C);
    frame_q = '{8'h12, 8'h34};
    apply_frame(0, 0);
    check_output("t1_miso0", miso_q[0], 8'hA5);
    check_output("t1_miso1", miso_q[1], 8'h3C);
    check_output("t1_head0", rx_dout, 8'h12);
`ifdef SPI_TARGET_FRAME_CNT_EN
    check_output("t1_frame_bytes", frame_bytes, 2);
`endif
    apply_rx_read();
    check_output("t1_head1", rx_dout, 8'h34);
    apply_rx_read();
    check_output("t1_tx_empty", tx_empty, 1);
    check_output("t1_flags", {rx_ovf, tx_unf, frame_err}, 0);

    // Underflow: empty TX sends the idle byte.
    frame_q = '{8'h55};
    apply_frame(0, 0);
    check_output("t2_miso", miso_q[0], 8'hFF);
    check_output("t2_tx_unf", tx_unf, 1);
    check_output("t2_head", rx_dout, 8'h55);
    apply_err_clr();
    check_output("t2_unf_clr", tx_unf, 0);
    apply_rx_read();

    // Aborted byte after 5 sck edges, then a clean frame.
    apply_frame(3, 0);
    check_output("t4_frame_err", frame_err, 1);
    check_output("t4_no_push", rx_data_avail, 0);
    check_output("t4_miso", miso, 1);
    apply_err_clr();
    frame_q = '{8'h77};
    apply_frame(0, 0);
    check_output("t4_head", rx_dout, 8'h77);
    apply_rx_read();

    // RX overflow.
    for (int i = 0; i < 16; i++) frame_q.push_back(8'h10 + 8'(i));
    apply_frame(0, 0);
    frame_q = '{8'h99};
    apply_frame(0, 0);
    check_output("t3_rx_ovf", rx_ovf, 1);
    check_output("t3_head", rx_dout, 8'h10);
    for (int i = 0; i < 16; i++) apply_rx_read();
    apply_err_clr();

    // Core pop coinciding with the SPI push into a one-entry RX.
    frame_q = '{8'h21};
    apply_frame(0, 0);
    frame_q = '{8'h42};
    apply_frame(0, 1);
    check_output("t6_head", rx_dout, 8'h42);
    check_output("t6_avail", rx_data_avail, 1);
    apply_rx_read();

    // TX full: the seventeenth write is dropped.
    for (int i = 0; i < 17; i++) begin
      r = $urandom;
      apply_tx_write(r[7:0]);
    end
    check_output("tx_full_lit", tx_full, 1);
    for (int i = 0; i < 16; i++) begin
      r = $urandom;
      frame_q.push_back(r[7:0]);
    end
    apply_frame(0, 0);
    check_output("tx_drained", tx_empty, 1);
    for (int i = 0; i < 16; i++) apply_rx_read();

    // Randomized traffic.
    for (int it = 0; it < 20; it++) begin
      nw = int'($urandom_range(0, 3));
      for (int i = 0; i < nw; i++) begin
        r = $urandom;
        apply_tx_write(r[7:0]);
      end
      nb = int'($urandom_range(1, 3));
      for (int i = 0; i < nb; i++) begin
        r = $urandom;
        frame_q.push_back(r[7:0]);
      end
      part = 0;
      if ($urandom_range(0, 3) == 0) part = int'($urandom_range(1, 7));
      apply_frame(part, 0);
      nr = int'($urandom_range(0, 3));
      for (int i = 0; i < nr; i++) apply_rx_read();
      if ($urandom_range(0, 4) == 0) apply_err_clr();
    end

    // Reset mid-byte, then a frame on the emptied TX.
    apply_tx_write(8'hC1);
    apply_tx_write(8'hC2);
    apply_reset_mid_frame();
    frame_q = '{8'hAB};
    apply_frame(0, 0);
    check_output("t5_miso", miso_q[0], 8'hFF);
    check_output("t5_tx_unf", tx_unf, 1);
    check_output("t5_head", rx_dout, 8'hAB);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
